// File: rtl/bin2bcd_pkg.sv
// Purpose: shared constants and FSM state type for the sequential binary-to-BCD converter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bin2bcd_pkg;

  localparam int DIGIT_W = 4;

  // Shift-add-3: a digit of 5 or more would exceed 9 after doubling, so pre-add 3.
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Purpose: single BCD digit pre-shift adjust (digit >= 5 gets +3).
// Latency: combinational.
// Backpressure: none.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= ADJ_THRESH) ? (din + ADJ_ADD) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Purpose: multi-cycle binary-to-BCD converter with signed mode, sticky overflow and leading-zero mask.
// Latency: BIN_W+1 clocks from accepted start to the done pulse; one bit converted per clock.
// Backpressure: start is ignored while busy (no queueing); start in the done cycle is accepted.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 8
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic                      start,
  input  logic                      signed_mode,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]         blank_out,
  output logic                      neg_out,
  output logic                      ovf_out
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  state_t            state;
  state_t            state_nxt;
  logic [SR_W-1:0]   sr;
  logic [CNT_W-1:0]  step;
  logic              neg_q;
  logic              ovf_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic [SR_W-1:0]   sr_shift;
  logic              carry_out;
  logic              accept;
  logic              is_neg;
  logic [BIN_W-1:0]  mag;
  logic [DIGITS-1:0] blank_nxt;
  logic              all_zero;

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);

  // Most negative input negates to itself, which as unsigned is exactly 2**(BIN_W-1).
  assign is_neg = signed_mode && bin_in[BIN_W-1];
  assign mag    = is_neg ? ((~bin_in) + BIN_W'(1)) : bin_in;

  // One adjust cell per digit of the BCD half of the shift register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .din  (sr[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .dout (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // A bit falling off the top digit means the value no longer fits; the rest stays value mod 10**DIGITS.
  assign carry_out = bcd_adj[BCD_W-1];
  assign sr_shift  = {bcd_adj[BCD_W-2:0], sr[BIN_W-1:0], 1'b0};

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one cycle idle-accept, BIN_W shift steps, one cycle to publish.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (step == LAST_STEP) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working datapath: capture on accept, adjust-and-shift each SHIFT cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sr    <= '0;
      step  <= '0;
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      sr    <= {{BCD_W{1'b0}}, mag};
      step  <= '0;
      neg_q <= is_neg;
      ovf_q <= 1'b0;
    end else if (state == SHIFT) begin
      sr    <= sr_shift;
      step  <= step + CNT_W'(1);
      ovf_q <= ovf_q | carry_out;
    end
  end

  // Leading-zero mask from the final digits; the units digit is never blanked.
  always_comb begin
    blank_nxt = '0;
    all_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero     = all_zero && (sr[BIN_W + i*DIGIT_W +: DIGIT_W] == '0);
      blank_nxt[i] = all_zero;
    end
  end

  // Result registers: updated only when a conversion completes, otherwise held.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      done      <= 1'b0;
      bcd_out   <= '0;
      blank_out <= BLANK_RST;
      neg_out   <= 1'b0;
      ovf_out   <= 1'b0;
    end else begin
      done <= (state == FINISH);
      if (state == FINISH) begin
        bcd_out   <= sr[SR_W-1:BIN_W];
        blank_out <= blank_nxt;
        neg_out   <= neg_q;
        ovf_out   <= ovf_q;
      end
    end
  end

endmodule
